csa_operand_collector: RTL

- Upstream feeder for the multi-operand carry-save adder.
- Accepts a serial stream of OP_W-bit operands (pixels) over a valid/ready handshake.
- Packs each group of NUM_COUNT operands into the adder's flat operand bus and holds it stable until consumed.
- Double-buffered (fill + output register), so the input streams at one operand per cycle while the adder side applies backpressure.

---
 rtl/csa_operand_collector.sv | 127 ++++++++++++
 1 files changed

// File: rtl/csa_operand_collector.sv
// ---------------------------------------------------------------------------
// csa_operand_collector: packs a serial operand stream into NUM_COUNT-wide
// groups for the carry-save adder, double-buffered behind a valid/ready port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csa_operand_collector #(
  parameter int OP_W      = 4,
  parameter int NUM_COUNT = 4,
  parameter int CNT_W     = $clog2(NUM_COUNT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_data,
  input  logic                      in_last,
  output logic                      nums_valid,
  input  logic                      nums_ready,
  output logic [OP_W*NUM_COUNT-1:0] nums,
  output logic [CNT_W-1:0]          nums_count
);

  localparam int FILL_W = $clog2(NUM_COUNT);
  localparam int BUS_W  = OP_W * NUM_COUNT;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BUS_W-1:0]    fill_buf_q, fill_buf_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [BUS_W-1:0]    nums_q, nums_d;
  logic [CNT_W-1:0]    nums_count_q, nums_count_d;
  logic                nums_valid_q, nums_valid_d;

  logic [BUS_W-1:0]    merged;
  logic                in_fire;
  logic                out_free;
  logic                last_slot;

  assign in_ready  = (state_q == FILL);
  assign in_fire   = in_valid && in_ready;
  assign out_free  = !nums_valid_q || nums_ready;
  assign last_slot = (fill_cnt_q == FILL_W'(NUM_COUNT - 1));

  // Fill buffer is cleared after every group, so unwritten slots stay zero.
  always_comb begin
    merged = fill_buf_q;
    for (int k = 0; k < NUM_COUNT; k++) begin
      if (fill_cnt_q == FILL_W'(k)) begin
        merged[k*OP_W +: OP_W] = in_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_buf_d   = fill_buf_q;
    fill_cnt_d   = fill_cnt_q;
    nums_d       = nums_q;
    nums_count_d = nums_count_q;
    nums_valid_d = nums_valid_q && !nums_ready;

    case (state_q)
      FILL: begin
        if (in_fire) begin
          if (last_slot || in_last) begin
            if (out_free) begin
              nums_d       = merged;
              nums_count_d = CNT_W'(fill_cnt_q) + 1'b1;
              nums_valid_d = 1'b1;
              fill_buf_d   = '0;
              fill_cnt_d   = '0;
            end else begin
              // Group parks in the fill buffer; fill_cnt keeps its last slot index.
              fill_buf_d = merged;
              state_d    = PEND;
            end
          end else begin
            fill_buf_d = merged;
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      PEND: begin
        if (out_free) begin
          nums_d       = fill_buf_q;
          nums_count_d = CNT_W'(fill_cnt_q) + 1'b1;
          nums_valid_d = 1'b1;
          fill_buf_d   = '0;
          fill_cnt_d   = '0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      fill_buf_q   <= '0;
      fill_cnt_q   <= '0;
      nums_q       <= '0;
      nums_count_q <= '0;
      nums_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_buf_q   <= fill_buf_d;
      fill_cnt_q   <= fill_cnt_d;
      nums_q       <= nums_d;
      nums_count_q <= nums_count_d;
      nums_valid_q <= nums_valid_d;
    end
  end

  assign nums       = nums_q;
  assign nums_count = nums_count_q;
  assign nums_valid = nums_valid_q;

endmodule

`default_nettype wire
